// File: rtl/instr_mem_ctrl.sv
// Fetch-stage instruction RAM: zero-sweeps after reset, then serves word fetches with 1-cycle registered latency.
// fetch_ready only in RUN, load_ready only in LOAD; optional per-word parity under `IMEM_PARITY_EN.
module instr_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [DATA_WIDTH-1:0]  load_data,
  input  logic                   load_last,
  output logic [$clog2(DEPTH):0] load_count,
`ifdef IMEM_PARITY_EN
  input  logic                   inject_parity_err,
`endif
  input  logic                   fetch_valid,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_ready,
  output logic                   instr_valid,
  output logic [DATA_WIDTH-1:0]  instr_out,
  output logic                   instr_fault,
  output logic                   busy
);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDXW-1:0]       ptr;
  logic [IDXW-1:0]       ptr_nxt;
  logic [IDXW:0]         count_nxt;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic                  wr_par;
  logic                  par_mem [DEPTH];
`endif
  logic                  fetch_acc;
  logic                  addr_fault;
  logic [IDXW-1:0]       fetch_idx;

  assign fetch_ready = (state == RUN);
  assign load_ready  = (state == LOAD);
  assign fetch_acc   = fetch_valid && fetch_ready;
  assign fetch_idx   = fetch_addr[IDXW+1:2];
  // Any address bit above the array span is a fault rather than an alias.
  assign addr_fault  = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (IDXW + 2)) != '0);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    count_nxt = load_count;
    wr_en     = 1'b0;
    wr_data   = '0;
`ifdef IMEM_PARITY_EN
    wr_par    = 1'b0;
`endif
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        ptr_nxt = ptr + IDXW'(1);
        if (ptr == LAST_IDX) state_nxt = RUN;
      end
      RUN: begin
        if (load_start) begin
          state_nxt = LOAD;
          ptr_nxt   = '0;
          count_nxt = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          wr_en     = 1'b1;
          wr_data   = load_data;
`ifdef IMEM_PARITY_EN
          wr_par    = (^load_data) ^ inject_parity_err;
`endif
          ptr_nxt   = ptr + IDXW'(1);
          count_nxt = load_count + (IDXW+1)'(1);
          if (load_last || (ptr == LAST_IDX)) state_nxt = RUN;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      ptr        <= '0;
      load_count <= '0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      load_count <= count_nxt;
      busy       <= (state_nxt != RUN);
    end
  end

  // Array has no reset: the CLEAR sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr]     <= wr_data;
`ifdef IMEM_PARITY_EN
      par_mem[ptr] <= wr_par;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_fault <= 1'b0;
    end else begin
      instr_valid <= fetch_acc;
      if (fetch_acc) begin
        if (addr_fault) begin
          instr_out   <= '0;
          instr_fault <= 1'b1;
        end else begin
          instr_out   <= mem[fetch_idx];
`ifdef IMEM_PARITY_EN
          instr_fault <= ((^mem[fetch_idx]) != par_mem[fetch_idx]);
`else
          instr_fault <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Randomised scoreboard bench for instr_mem_ctrl against an array-level model of the program image.
module tb_instr_mem_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   load_start = 1'b0;
  logic                   load_valid = 1'b0;
  logic                   load_ready;
  logic [DW-1:0]          load_data = '0;
  logic                   load_last = 1'b0;
  logic [$clog2(DEPTH):0] load_count;
`ifdef IMEM_PARITY_EN
  logic                   inject_parity_err = 1'b0;
`endif
  logic                   fetch_valid = 1'b0;
  logic [AW-1:0]          fetch_addr = '0;
  logic                   fetch_ready;
  logic                   instr_valid;
  logic [DW-1:0]          instr_out;
  logic                   instr_fault;
  logic                   busy;

  instr_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .load_count(load_count),
`ifdef IMEM_PARITY_EN
    .inject_parity_err(inject_parity_err),
`endif
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_fault(instr_fault),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
  } exp_t;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] model [DEPTH];
  bit            par_bad [DEPTH];
  exp_t          exp_q [$];
  logic [DW-1:0] img [$];
  logic [DW-1:0] last_d = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Expected response derived from the address rules and the image model.
  function automatic exp_t expect_of(input logic [AW-1:0] a);
    exp_t e;
    if (a[1:0] != 2'b00 || a >= AW'(4 * DEPTH)) begin
      e.d = '0;
      e.f = 1'b1;
    end else begin
      e.d = model[a >> 2];
      e.f = par_bad[a >> 2];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset && instr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_instr_valid", {31'b0, instr_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("instr_out", instr_out, e.d);
        chk("instr_fault", {31'b0, instr_fault}, {31'b0, e.f});
        last_d = e.d;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    exp_q.push_back(expect_of(a));
    step();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned k;
    logic [AW-1:0] a;
    k = $urandom_range(0, 9);
    if (k < 6)      a = AW'($urandom_range(0, DEPTH - 1) * 4);
    else if (k < 8) a = AW'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    else            a = $urandom() | (AW'(1) << $urandom_range(8, AW - 1));
    return a;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_load_ready"}, {31'b0, load_ready}, 32'd0);
    chk({tag, "_fetch_ready"}, {31'b0, fetch_ready}, 32'd0);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_instr_out"}, instr_out, 32'd0);
    chk({tag, "_instr_fault"}, {31'b0, instr_fault}, 32'd0);
    chk({tag, "_load_count"}, 32'(load_count), 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  // Release reset and sweep; load_start/fetch noise early in CLEAR must be ignored.
  task automatic clear_phase();
    int busy_cnt;
    busy_cnt = 0;
    reset = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      load_start  = (k < 10);
      fetch_valid = (k < 10);
      fetch_addr  = 32'h4;
      step();
      if (k < DEPTH && busy) busy_cnt++;
      if (k == DEPTH - 1) chk("fetch_ready_late_clear", {31'b0, fetch_ready}, 32'd0);
    end
    load_start  = 1'b0;
    fetch_valid = 1'b0;
    chk("clear_busy_cycles", busy_cnt, DEPTH - 1);
    chk("busy_after_clear", {31'b0, busy}, 32'd0);
    chk("fetch_ready_after_clear", {31'b0, fetch_ready}, 32'd1);
    chk("load_ready_after_clear", {31'b0, load_ready}, 32'd0);
  endtask

  task automatic run_load(input int n, input bit use_last, input bit gaps,
                          input bit with_fetch, input int inj_mode);
    int wr;
    int i;
    int guard;
    bit inj;
    wr = 0;
    i = 0;
    guard = 0;
    load_start = 1'b1;
    if (with_fetch) fetch(32'h8);
    else step();
    fetch_valid = 1'b0;
    load_start  = 1'b0;
    chk("load_ready_on_entry", {31'b0, load_ready}, 32'd1);
    chk("fetch_ready_in_load", {31'b0, fetch_ready}, 32'd0);
    chk("load_count_on_entry", 32'(load_count), 32'd0);
    chk("busy_in_load", {31'b0, busy}, 32'd1);
    while (i < n && wr < DEPTH && guard < 4000) begin
      guard++;
      load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_start = ($urandom_range(0, 7) == 0);
      load_data  = img[i];
      load_last  = use_last && (i == n - 1);
      inj = 1'b0;
      if (inj_mode == 1)      inj = (i == 0);
      else if (inj_mode == 2) inj = ($urandom_range(0, 5) == 0);
`ifdef IMEM_PARITY_EN
      inject_parity_err = inj;
`else
      inj = 1'b0;
`endif
      step();
      if (load_valid) begin
        model[wr]   = load_data;
        par_bad[wr] = inj;
        wr++;
        i++;
        if (load_last) break;
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_start = 1'b0;
`ifdef IMEM_PARITY_EN
    inject_parity_err = 1'b0;
`endif
    chk("load_count_final", 32'(load_count), wr);
    chk("load_ready_after_load", {31'b0, load_ready}, 32'd0);
    chk("busy_after_load", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    bit ul;
    for (int i = 0; i < DEPTH; i++) begin
      model[i]   = '0;
      par_bad[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    clear_phase();

    fetch(32'h00); fetch(32'h04); fetch(32'hFC);
    fetch_valid = 1'b0;
    step(); step();
    chk("idle_no_valid", {31'b0, instr_valid}, 32'd0);
    chk("idle_hold_out", instr_out, last_d);

    img = '{32'h00500093, 32'h00600113, 32'h002081B3, 32'h00000013};
    run_load(4, 1'b1, 1'b0, 1'b0, 0);
    fetch(32'h08);
    fetch_valid = 1'b0;
    step();

    fetch(32'h02); fetch(32'h100); fetch(32'hFC); fetch(32'h0C);
    fetch_valid = 1'b0;
    step();

    img.delete();
    for (int j = 0; j < 70; j++) img.push_back($urandom());
    run_load(70, 1'b0, 1'b0, 1'b1, 0);
    load_valid = 1'b1;
    load_data  = 32'hDEADBEEF;
    step(); step();
    load_valid = 1'b0;
    fetch(32'hFC); fetch(32'h00);
    fetch_valid = 1'b0;
    step(); step();

`ifdef IMEM_PARITY_EN
    img = '{32'h00000013, 32'h00000013};
    run_load(2, 1'b1, 1'b0, 1'b0, 1);
    fetch(32'h00); fetch(32'h04);
    fetch_valid = 1'b0;
    step(); step();
`endif

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        ul = ($urandom_range(0, 1) == 1);
        n  = ul ? $urandom_range(1, 80) : $urandom_range(DEPTH, 80);
        img.delete();
        for (int j = 0; j < n; j++) img.push_back($urandom());
        run_load(n, ul, 1'b1, ($urandom_range(0, 1) == 1), 2);
      end else begin
        n = $urandom_range(1, 8);
        for (int j = 0; j < n; j++) fetch(rand_addr());
        fetch_valid = 1'b0;
        if ($urandom_range(0, 1) == 1) step();
      end
    end
    fetch_valid = 1'b0;
    step(); step();

    img = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      load_valid = 1'b1;
      load_data  = img[j];
      step();
    end
    load_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_vals("mid_load_reset");
    for (int i = 0; i < DEPTH; i++) begin
      model[i]   = '0;
      par_bad[i] = 1'b0;
    end
    repeat (3) step();
    clear_phase();
    fetch(32'h00); fetch(32'h04);
    fetch_valid = 1'b0;
    repeat (3) step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
